// File: rtl/muller_c_pkg.sv
// Shared types and parameter limits for the Muller C-element array.
package muller_c_pkg;

  // Per-channel state; the output is high in ST_HIGH and ST_ARM_LO.
  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    ST_ARM_HI = 2'd1,
    ST_HIGH   = 2'd2,
    ST_ARM_LO = 2'd3
  } chan_state_e;

  localparam int unsigned NUM_CH_MIN = 1;
  localparam int unsigned NUM_CH_MAX = 16;
  localparam int unsigned N_IN_MIN   = 2;
  localparam int unsigned N_IN_MAX   = 8;
  localparam int unsigned FILT_MAX   = 15;
  localparam int unsigned FILT_W     = 4;

  // C-element output value implied by a channel state.
  function automatic logic state_is_high(input chan_state_e s);
    return (s == ST_HIGH) || (s == ST_ARM_LO);
  endfunction

endpackage

// File: rtl/muller_c_chan.sv
// Single C-element channel: two-flop input synchronizer, filtered
// LOW/ARM_HI/HIGH/ARM_LO state machine, edge pulses and, when
// MULLER_C_COUNT_EN is defined, a saturating transition counter.
module muller_c_chan
  import muller_c_pkg::*;
#(
  parameter int unsigned N_IN    = 3,
  parameter int unsigned FILT    = 2,
  parameter logic        RST_VAL = 1'b0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [N_IN-1:0] in_i,
  input  logic            en_i,
  output logic            c_o,
  output logic            rise_o,
  output logic            fall_o
`ifdef MULLER_C_COUNT_EN
  ,
  output logic [CNT_W-1:0] cnt_o
`endif
);

  if (N_IN < N_IN_MIN || N_IN > N_IN_MAX || FILT > FILT_MAX || CNT_W < 1) begin : g_param_err
    $error("muller_c_chan: parameter out of range");
  end

  localparam chan_state_e       RST_STATE = RST_VAL ? ST_HIGH : ST_LOW;
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'((FILT == 0) ? 0 : FILT - 1);

  logic [N_IN-1:0]   sync1_q, sync2_q;
  chan_state_e       state_q, state_d;
  logic [FILT_W-1:0] filt_q, filt_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              all1, all0;
  logic              c_now, c_next;

  // Two-flop synchronizer on every input bit; keeps running when disabled.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync1_q <= {N_IN{RST_VAL}};
      sync2_q <= {N_IN{RST_VAL}};
    end else begin
      sync1_q <= in_i;
      sync2_q <= sync1_q;
    end
  end

  assign all1 = &sync2_q;
  assign all0 = ~|sync2_q;

  // Next-state and filter counter; mixed samples never move toward a switch.
  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    if (!en_i) begin
      filt_d = '0;
    end else begin
      unique case (state_q)
        ST_LOW: begin
          filt_d = '0;
          if (all1) state_d = (FILT == 0) ? ST_HIGH : ST_ARM_HI;
        end
        ST_ARM_HI: begin
          if (!all1) begin
            state_d = ST_LOW;
            filt_d  = '0;
          end else if (filt_q == FILT_LAST) begin
            state_d = ST_HIGH;
            filt_d  = '0;
          end else begin
            filt_d = filt_q + FILT_W'(1);
          end
        end
        ST_HIGH: begin
          filt_d = '0;
          if (all0) state_d = (FILT == 0) ? ST_LOW : ST_ARM_LO;
        end
        ST_ARM_LO: begin
          if (!all0) begin
            state_d = ST_HIGH;
            filt_d  = '0;
          end else if (filt_q == FILT_LAST) begin
            state_d = ST_LOW;
            filt_d  = '0;
          end else begin
            filt_d = filt_q + FILT_W'(1);
          end
        end
        default: begin
          state_d = RST_STATE;
          filt_d  = '0;
        end
      endcase
    end
  end

  // Pulses are registered alongside the state so they line up with c_o.
  always_comb begin
    c_now  = state_is_high(state_q);
    c_next = state_is_high(state_d);
    rise_d = c_next & ~c_now;
    fall_d = c_now & ~c_next;
  end

  // State, filter and pulse registers; reset aborts any pending transition.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= RST_STATE;
      filt_q  <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign c_o    = state_is_high(state_q);
  assign rise_o = rise_q;
  assign fall_o = fall_q;

`ifdef MULLER_C_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of reported transitions.
  always_comb begin
    cnt_d = cnt_q;
    if ((rise_d || fall_d) && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Transition counter register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/muller_c_array.sv
// Array of NUM_CH independent filtered Muller C-elements.
// Optional feature: MULLER_C_COUNT_EN adds per-channel transition
// counters and the cnt_o port.
module muller_c_array
  import muller_c_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned N_IN    = 3,
  parameter int unsigned FILT    = 2,
  parameter logic        RST_VAL = 1'b0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic [NUM_CH*N_IN-1:0] in_i,
  input  logic [NUM_CH-1:0]      en_i,
  output logic [NUM_CH-1:0]      c_o,
  output logic [NUM_CH-1:0]      rise_o,
  output logic [NUM_CH-1:0]      fall_o,
  output logic                   all_hi_o
`ifdef MULLER_C_COUNT_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] cnt_o
`endif
);

  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_param_err
    $error("muller_c_array: NUM_CH out of range");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    muller_c_chan #(
      .N_IN    (N_IN),
      .FILT    (FILT),
      .RST_VAL (RST_VAL),
      .CNT_W   (CNT_W)
    ) u_chan (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .in_i     (in_i[c*N_IN +: N_IN]),
      .en_i     (en_i[c]),
      .c_o      (c_o[c]),
      .rise_o   (rise_o[c]),
      .fall_o   (fall_o[c])
`ifdef MULLER_C_COUNT_EN
      ,
      .cnt_o    (cnt_o[c*CNT_W +: CNT_W])
`endif
    );
  end

  assign all_hi_o = &c_o;

endmodule

// File: doc/muller_c_array.md
MULLER_C_ARRAY -- requirements
Module: muller_c_array

Interface
REQ-001 SHALL provide parameter NUM_CH, default 4, number of independent C-element channels (1..16).
REQ-002 SHALL provide parameter N_IN, default 3, inputs per channel (2..8).
REQ-003 SHALL provide parameter FILT, default 2, extra consecutive unanimous samples required before switching (0..15).
REQ-004 SHALL provide parameter RST_VAL, default 1'b0, reset state of every channel output.
REQ-005 SHALL provide parameter CNT_W, default 16, transition counter width.
REQ-006 SHALL provide port wb_clk_i, input, 1, the single clock.
REQ-007 SHALL provide port wb_rst_i, input, 1, reset, synchronous and active-high.
REQ-008 SHALL provide port in_i, input, NUM_CH*N_IN, channel c owns bits [c*N_IN +: N_IN], may be asynchronous.
REQ-009 SHALL provide port en_i, input, NUM_CH, per-channel enable.
REQ-010 SHALL provide port c_o, output, NUM_CH, registered C-element outputs.
REQ-011 SHALL provide port rise_o, output, NUM_CH, one-cycle pulse on c_o 0->1.
REQ-012 SHALL provide port fall_o, output, NUM_CH, one-cycle pulse on c_o 1->0.
REQ-013 SHALL provide port all_hi_o, output, 1, AND of c_o.
REQ-014 SHALL provide port cnt_o, output, NUM_CH*CNT_W, per-channel transition counts; present only under MULLER_C_COUNT_EN.

Function
REQ-015 SHALL pass every in_i bit through a two-flop synchronizer before any use.
REQ-016 SHALL run per channel a state machine: LOW, ARM_HI, HIGH, ARM_LO.
REQ-017 In LOW, all-ones sample SHALL go to ARM_HI, or to HIGH directly when FILT=0; otherwise stay.
REQ-018 In ARM_HI, a filter counter SHALL count all-ones samples; on reaching FILT go to HIGH; any non-all-ones sample SHALL return to LOW and clear the counter.
REQ-019 HIGH/ARM_LO SHALL mirror REQ-017/018 with all-zeros samples.
REQ-020 Mixed samples SHALL never change c_o (hold behaviour).
REQ-021 c_o SHALL be 1 in HIGH and ARM_LO, 0 in LOW and ARM_HI.
REQ-022 Latency: inputs unanimous and stable from before edge k SHALL make c_o change after edge k+2+FILT.
REQ-023 rise_o/fall_o SHALL assert in exactly the cycle c_o first shows its new value.
REQ-024 With en_i[c]=0 the channel SHALL hold state and c_o, clear its filter counter, and emit no pulses; synchronizers keep running.
REQ-025 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL all be reported in the same cycle.

Reset
REQ-026 While wb_rst_i=1 at an edge: synchronizer flops = {N_IN{RST_VAL}}, state = HIGH if RST_VAL else LOW, filter counters 0, rise_o=fall_o=0, cnt_o=0.
REQ-027 Reset asserted mid-ARM SHALL abort the pending transition with no pulse emitted.
REQ-028 First cycle after reset release SHALL produce no pulse regardless of in_i.

Configuration
REQ-029 Macro MULLER_C_COUNT_EN defined: per-channel CNT_W counters increment on each rise_o or fall_o, saturating at all-ones (no wrap).
REQ-030 Macro undefined: counters and cnt_o port SHALL be absent; all other behaviour identical.

Structure
REQ-031 Package muller_c_pkg SHALL hold the channel state enum typedef and parameter range limits.
REQ-032 One sub-module muller_c_chan SHALL implement a single channel (synchronizer, FSM, filter, pulses, optional counter), instantiated NUM_CH times.

Verification
REQ-033 Reset 2 cycles, RST_VAL=0 -> c_o=0, rise_o=fall_o=0, all_hi_o=0, cnt_o=0.
REQ-034 FILT=2, ch0 in 000->111 before edge k, held -> c_o[0]=1 after edge k+4, rise_o[0]=1 for that cycle only.
REQ-035 ch1 in 111 for 2 synced samples then 011 -> c_o[1] stays 0, no pulse; 110 held indefinitely -> no change.
REQ-036 en_i[2]=0, in 111 held 10 cycles -> c_o[2]=0; en_i[2]->1 at edge j -> c_o[2]=1 after edge j+FILT.
REQ-037 MULLER_C_COUNT_EN, CNT_W=4, 20 full toggles on ch3 -> cnt_o ch3 = 15 (saturated); without macro, build has no cnt_o.
REQ-038 wb_rst_i pulsed while ch0 in ARM_LO -> c_o[0]=RST_VAL next cycle, no fall_o pulse.
